// File: rtl/datapath_regfile.sv
// -----------------------------------------------------------------------------
// datapath_regfile
//
// Small datapath: a sample hold register, 16 x 16-bit general registers
// (r15 is hard-wired to zero) and a 16-bit signed adder. Each clock edge can
// perform one NOP / LOAD / COPY / ADD into a destination register.
//
// Ports
//   clk          in   1   system clock, all state updates on rising edge
//   n_reset      in   1   asynchronous active-low reset
//   dr           in   1   data ready: hold register captures data_in
//   data_in      in  16   signed input sample
//   op           in   2   00 NOP, 01 LOAD, 10 COPY, 11 ADD
//   src1         in   4   first source register index
//   src2         in   4   second source register index
//   dest         in   4   destination register index
//   overflow     out  1   signed overflow of the ADD being presented
//   outreg_data  out 16   registered copy of r0
// -----------------------------------------------------------------------------
module datapath_regfile (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        dr,
    input  logic [15:0] data_in,
    input  logic [1:0]  op,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic [3:0]  dest,
    output logic        overflow,
    output logic [15:0] outreg_data
);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_COPY = 2'b10,
        OP_ADD  = 2'b11
    } op_e;

    logic [15:0] hold_q;
    logic [15:0] outreg_q;
    logic [15:0] rf_rd [16];   // read view of the file, r15 tied to zero
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] sum;
    logic [15:0] wdata;
    logic        wen;
    logic [15:0] r0_d;

    // ---------------------------------------------------------------------
    // Register file r0..r14, one flop bank per register.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_reg
            logic [15:0] reg_q;
            logic        we;

            assign we = wen && (dest == 4'(gi));

            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    reg_q <= '0;
                end else if (we) begin
                    reg_q <= wdata;
                end
            end

            assign rf_rd[gi] = reg_q;
        end
    endgenerate

    // Writes to r15 have no flop to land in, so they are simply lost.
    assign rf_rd[15] = '0;

    // ---------------------------------------------------------------------
    // Sample hold register.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_q <= '0;
        end else if (dr) begin
            hold_q <= data_in;
        end
    end

    // ---------------------------------------------------------------------
    // Combinational read, add and write-data select. All operands come from
    // current (pre-edge) register contents, so read-modify-write of the same
    // register needs no forwarding.
    // ---------------------------------------------------------------------
    assign rd1 = rf_rd[src1];
    assign rd2 = rf_rd[src2];
    assign sum = rd1 + rd2;

    always_comb begin
        wen   = 1'b0;
        wdata = '0;
        case (op)
            OP_LOAD: begin
                wen   = 1'b1;
                wdata = hold_q;
            end
            OP_COPY: begin
                wen   = 1'b1;
                wdata = rd1;
            end
            OP_ADD: begin
                wen   = 1'b1;
                wdata = sum;
            end
            default: begin
                wen   = 1'b0;
                wdata = '0;
            end
        endcase
    end

    // Same-sign operands producing an opposite-sign sum. Gated by reset so
    // the flag stays low while the design is held in reset.
    assign overflow = n_reset && (op == OP_ADD) &&
                      (rd1[15] == rd2[15]) && (sum[15] != rd1[15]);

    // ---------------------------------------------------------------------
    // Output register tracks the value r0 will hold after this edge, so it
    // never lags r0.
    // ---------------------------------------------------------------------
    assign r0_d = (wen && (dest == 4'd0)) ? wdata : rf_rd[0];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            outreg_q <= '0;
        end else begin
            outreg_q <= r0_d;
        end
    end

    assign outreg_data = outreg_q;

endmodule

// File: tb/tb_datapath_regfile.sv
// -----------------------------------------------------------------------------
// tb_datapath_regfile
//
// Directed vector table, hand-written reset sequence and randomized traffic
// checked against an arithmetic reference model of the datapath.
// -----------------------------------------------------------------------------
module tb_datapath_regfile;

    logic        clk;
    logic        n_reset;
    logic        dr;
    logic [15:0] data_in;
    logic [1:0]  op;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic        overflow;
    logic [15:0] outreg_data;

    int total;
    int bad;

    datapath_regfile dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .dr         (dr),
        .data_in    (data_in),
        .op         (op),
        .src1       (src1),
        .src2       (src2),
        .dest       (dest),
        .overflow   (overflow),
        .outreg_data(outreg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model: plain array of register values plus the hold value.
    // ---------------------------------------------------------------------
    logic [15:0] m_r [16];
    logic [15:0] m_hold;

    function automatic logic [15:0] m_read(input logic [3:0] idx);
        if (idx == 4'd15) return 16'h0000;
        return m_r[idx];
    endfunction

    function automatic int to_int(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
        m_hold = 16'h0000;
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction. Entered ~1 time unit after a rising edge; returns the
    // same point after the next rising edge. Reports the model's predictions
    // and the DUT's observations.
    task automatic do_cycle(input logic t_dr, input logic [15:0] t_din,
                            input logic [1:0] t_op, input logic [3:0] t_s1,
                            input logic [3:0] t_s2, input logic [3:0] t_d,
                            output logic exp_ovf, output logic [15:0] exp_out,
                            output logic got_ovf, output logic [15:0] got_out);
        int          a;
        int          b;
        int          s;
        logic        wr;
        logic [15:0] wv;
        dr      = t_dr;
        data_in = t_din;
        op      = t_op;
        src1    = t_s1;
        src2    = t_s2;
        dest    = t_d;
        a = to_int(m_read(t_s1));
        b = to_int(m_read(t_s2));
        s = a + b;
        exp_ovf = (t_op == 2'b11) && ((s > 32767) || (s < -32768));
        wr = 1'b1;
        wv = 16'h0000;
        case (t_op)
            2'b01:   wv = m_hold;
            2'b10:   wv = m_read(t_s1);
            2'b11:   wv = 16'(s);
            default: wr = 1'b0;
        endcase
        @(negedge clk);
        got_ovf = overflow;
        @(posedge clk);
        if (wr && t_d != 4'd15) m_r[t_d] = wv;
        if (t_dr) m_hold = t_din;
        exp_out = m_r[0];
        #1;
        got_out = outreg_data;
        $display("txn dr=%0b din=%h op=%0d s1=%0d s2=%0d d=%0d ovf=%0b out=%h",
                 t_dr, t_din, t_op, t_s1, t_s2, t_d, got_ovf, got_out);
    endtask

    // Directed vector table.
    typedef struct {
        logic        v_dr;
        logic [15:0] v_din;
        logic [1:0]  v_op;
        logic [3:0]  v_s1;
        logic [3:0]  v_s2;
        logic [3:0]  v_d;
        logic        v_ovf;
        logic [15:0] v_out;
    } vec_t;

    vec_t vecs [26];

    // Bounded run time in case anything stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        eo;
        logic        go;
        logic [15:0] ex;
        logic [15:0] gx;

        total = 0;
        bad   = 0;

        //         dr  din       op     s1  s2  d   ovf  out
        vecs[0]  = '{1'b1, 16'h1234, 2'b00, 0, 0, 0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0000, 2'b01, 0, 0, 5, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 16'h0000, 2'b10, 5, 0, 0, 1'b0, 16'h1234};
        vecs[3]  = '{1'b1, 16'h0003, 2'b00, 0, 0, 0, 1'b0, 16'h1234};
        vecs[4]  = '{1'b1, 16'hFFFE, 2'b01, 0, 0, 1, 1'b0, 16'h1234};
        vecs[5]  = '{1'b0, 16'h0000, 2'b01, 0, 0, 2, 1'b0, 16'h1234};
        vecs[6]  = '{1'b0, 16'h0000, 2'b11, 1, 2, 0, 1'b0, 16'h0001};
        vecs[7]  = '{1'b1, 16'h7FFF, 2'b00, 0, 0, 0, 1'b0, 16'h0001};
        vecs[8]  = '{1'b1, 16'h0001, 2'b01, 0, 0, 1, 1'b0, 16'h0001};
        vecs[9]  = '{1'b1, 16'h8000, 2'b01, 0, 0, 2, 1'b0, 16'h0001};
        vecs[10] = '{1'b0, 16'h0000, 2'b11, 1, 2, 0, 1'b1, 16'h8000};
        vecs[11] = '{1'b1, 16'hFFFF, 2'b01, 0, 0, 1, 1'b0, 16'h8000};
        vecs[12] = '{1'b0, 16'h0000, 2'b01, 0, 0, 2, 1'b0, 16'h8000};
        vecs[13] = '{1'b0, 16'h0000, 2'b11, 1, 2, 0, 1'b1, 16'h7FFF};
        vecs[14] = '{1'b0, 16'h0000, 2'b10, 1, 0, 15, 1'b0, 16'h7FFF};
        vecs[15] = '{1'b0, 16'h0000, 2'b11, 15, 15, 3, 1'b0, 16'h7FFF};
        vecs[16] = '{1'b0, 16'h0000, 2'b10, 3, 0, 0, 1'b0, 16'h0000};
        vecs[17] = '{1'b0, 16'h0000, 2'b10, 1, 0, 0, 1'b0, 16'h8000};
        vecs[18] = '{1'b0, 16'h0000, 2'b10, 15, 0, 0, 1'b0, 16'h0000};
        vecs[19] = '{1'b1, 16'h00AA, 2'b00, 0, 0, 0, 1'b0, 16'h0000};
        vecs[20] = '{1'b1, 16'h0055, 2'b01, 0, 0, 4, 1'b0, 16'h0000};
        vecs[21] = '{1'b0, 16'h0000, 2'b01, 0, 0, 0, 1'b0, 16'h0055};
        vecs[22] = '{1'b0, 16'h0000, 2'b10, 4, 0, 0, 1'b0, 16'h00AA};
        vecs[23] = '{1'b0, 16'h0000, 2'b11, 0, 0, 0, 1'b0, 16'h0154};
        vecs[24] = '{1'b0, 16'h0000, 2'b10, 1, 0, 0, 1'b0, 16'h8000};
        vecs[25] = '{1'b0, 16'h0000, 2'b11, 0, 0, 0, 1'b1, 16'h0000};

        dr = 0; data_in = 0; op = 0; src1 = 0; src2 = 0; dest = 0;
        n_reset = 1'b1;
        m_reset();

        // Reset state, observed before any clock edge.
        #1 n_reset = 1'b0;
        #2;
        check("reset_out", outreg_data, 16'h0000);
        check("reset_ovf", {15'd0, overflow}, 16'h0000);
        @(posedge clk);
        #1 n_reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 26; i++) begin
            do_cycle(vecs[i].v_dr, vecs[i].v_din, vecs[i].v_op, vecs[i].v_s1,
                     vecs[i].v_s2, vecs[i].v_d, eo, ex, go, gx);
            check($sformatf("vec%0d_ovf", i), {15'd0, go}, {15'd0, vecs[i].v_ovf});
            check($sformatf("vec%0d_out", i), gx, vecs[i].v_out);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 16'($urandom),
                     2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     eo, ex, go, gx);
            check("rand_ovf", {15'd0, go}, {15'd0, eo});
            check("rand_out", gx, ex);
        end

        // Mid-cycle asynchronous reset with an overflowing ADD presented.
        do_cycle(1'b1, 16'h4000, 2'b00, 0, 0, 0, eo, ex, go, gx);
        do_cycle(1'b1, 16'h4000, 2'b01, 0, 0, 1, eo, ex, go, gx);
        do_cycle(1'b0, 16'h0000, 2'b01, 0, 0, 2, eo, ex, go, gx);
        do_cycle(1'b0, 16'h0000, 2'b01, 0, 0, 0, eo, ex, go, gx);
        check("pre_rst_out", gx, 16'h4000);
        op = 2'b11; src1 = 4'd1; src2 = 4'd2; dest = 4'd0;
        #2;
        check("pre_rst_ovf", {15'd0, overflow}, 16'h0001);
        n_reset = 1'b0;
        #1;
        check("async_rst_out", outreg_data, 16'h0000);
        check("async_rst_ovf", {15'd0, overflow}, 16'h0000);
        m_reset();
        // Hold reset across an edge: the pending ADD must not land.
        @(posedge clk);
        #1;
        check("rst_hold_out", outreg_data, 16'h0000);
        n_reset = 1'b1;

        // First edge after release executes the op presented: ADD r1+r2 -> r0
        // on cleared registers gives zero with no overflow.
        do_cycle(1'b0, 16'h0000, 2'b11, 1, 2, 0, eo, ex, go, gx);
        check("post_rst_ovf", {15'd0, go}, 16'h0000);
        check("post_rst_add", gx, 16'h0000);
        // Hold register cleared.
        do_cycle(1'b0, 16'h0000, 2'b01, 0, 0, 0, eo, ex, go, gx);
        check("post_rst_hold", gx, 16'h0000);
        // Every register cleared.
        for (int k = 1; k < 16; k++) begin
            do_cycle(1'b0, 16'h0000, 2'b10, 4'(k), 0, 0, eo, ex, go, gx);
            check($sformatf("post_rst_r%0d", k), gx, 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
